// File: rtl/z80_bus_arbiter.sv
// Bus arbiter sharing one memory array between the tv80s CPU and a DMA requester.
// Optional BUSAK watchdog is enabled by defining ARB_WATCHDOG_EN.
module z80_bus_arbiter #(
    parameter int MAX_HOLD      = 16,
    parameter int MIN_CPU       = 8,
    parameter int BUSAK_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    output logic        cpu_busrq_n,
    input  logic        cpu_busak_n,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_mreq_n,
    input  logic        cpu_wr_n,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [15:0] dma_addr,
    input  logic [7:0]  dma_wdata,
    output logic        dma_ack,
    output logic [7:0]  dma_rdata,
    output logic        dma_err,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    input  logic [7:0]  mem_rdata,
    output logic        mem_owner
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_GRANT   = 3'd2,
        S_RELEASE = 3'd3,
        S_COOL    = 3'd4
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        busrq_q;
    logic        owner_q;
    logic        busrq_d;
    logic        owner_d;
    logic [7:0]  hold_cnt;
    logic [7:0]  cool_cnt;
    logic        in_flight;
    logic [7:0]  rdata_q;
    logic        hold_expired;
    logic        cool_done;
    logic        accept;
    logic        wd_fire;

    // Expiry uses >= so an ack that lands past the limit still releases right after.
    assign hold_expired = (hold_cnt >= 8'(MAX_HOLD - 1));
    assign cool_done    = (cool_cnt == 8'(MIN_CPU - 1));
    assign accept       = (state == S_GRANT) && dma_req && !in_flight && !hold_expired;

    // State register, with bus control registered alongside it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            busrq_q <= 1'b1;
            owner_q <= 1'b0;
        end else begin
            state   <= state_next;
            busrq_q <= busrq_d;
            owner_q <= owner_d;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (dma_req) state_next = S_REQ;
            S_REQ: begin
                if (!dma_req)         state_next = S_RELEASE;
                else if (!cpu_busak_n) state_next = S_GRANT;
                else if (wd_fire)      state_next = S_RELEASE;
            end
            S_GRANT:   if (!in_flight && (!dma_req || hold_expired)) state_next = S_RELEASE;
            S_RELEASE: if (cpu_busak_n) state_next = S_COOL;
            S_COOL:    if (cool_done) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busrq_d = !((state_next == S_REQ) || (state_next == S_GRANT));
        owner_d = (state_next == S_GRANT);
    end

    assign cpu_busrq_n = busrq_q;
    assign mem_owner   = owner_q;

    // Counters are held at zero outside their state, so they start from zero on entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt  <= 8'd0;
            cool_cnt  <= 8'd0;
            in_flight <= 1'b0;
            rdata_q   <= 8'd0;
        end else begin
            in_flight <= accept;
            if (in_flight) rdata_q <= mem_rdata;
            if (state == S_GRANT) begin
                if (hold_cnt != 8'hff) hold_cnt <= hold_cnt + 8'd1;
            end else begin
                hold_cnt <= 8'd0;
            end
            if (state == S_COOL) cool_cnt <= cool_cnt + 8'd1;
            else                 cool_cnt <= 8'd0;
        end
    end

    // mem_rdata is registered, so read data is live on the bus during the ack cycle.
    assign dma_ack   = in_flight;
    assign dma_rdata = in_flight ? mem_rdata : rdata_q;

    always_comb begin
        if (owner_q) begin
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            mem_we    = accept && dma_we;
        end else begin
            mem_addr  = cpu_a;
            mem_wdata = cpu_dout;
            mem_we    = !cpu_mreq_n && !cpu_wr_n;
        end
    end

`ifdef ARB_WATCHDOG_EN
    logic [15:0] wd_cnt;
    logic        err_q;

    assign wd_fire = (state == S_REQ) && dma_req && cpu_busak_n &&
                     (wd_cnt == 16'(BUSAK_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt <= 16'd0;
            err_q  <= 1'b0;
        end else begin
            err_q <= wd_fire;
            if (state == S_REQ) begin
                if (wd_cnt != 16'hffff) wd_cnt <= wd_cnt + 16'd1;
            end else begin
                wd_cnt <= 16'd0;
            end
        end
    end

    assign dma_err = err_q;
`else
    assign wd_fire = 1'b0;
    assign dma_err = (BUSAK_TIMEOUT < 0);
`endif

endmodule
